// File: rtl/psk_burst_sequencer.sv
// psk_burst_sequencer: serial code source for the 2PSK modulator mux.
// Accepts parallel words over valid/ready and sends each burst as an
// alternating 1,0,... preamble followed by the words, MSB-first, with a
// programmable bit period. A one-word holding buffer chains words with no gap.
// Optional feature macro: PSK_SEQ_SCRAMBLE_EN (additive PN7 scrambler on
// data bits only). When the macro is undefined, data is sent unscrambled.
module psk_burst_sequencer #(
    parameter int DIV_W   = 16,
    parameter int WORD_W  = 8,
    parameter int PRE_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  bit_div,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              m_ser_code_out,
    output logic              bit_strobe,
    output logic              busy
);

    localparam int MAX_LEN = (PRE_LEN > WORD_W) ? PRE_LEN : WORD_W;
    localparam int IDX_W   = $clog2(MAX_LEN + 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DRAIN} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_l, div_n;
    logic [DIV_W-1:0]   cnt, cnt_n;
    logic [WORD_W-1:0]  shreg, shreg_n;
    logic [WORD_W-1:0]  hold, hold_n;
    logic               hold_full, hold_full_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               ser, ser_n;
    logic               strobe, strobe_n;
    logic               handshake;
    logic               bit_end;
    logic               scr_fb;

    // Ready is withheld during reset, while draining, and while the buffer is full
    assign tx_ready = !rst && enable &&
                      ((state == IDLE) ||
                       (((state == PRE) || (state == DATA)) && !hold_full));
    assign handshake      = tx_valid && tx_ready;
    assign bit_end        = (cnt == div_l);
    assign busy           = (state != IDLE);
    assign m_ser_code_out = ser;
    assign bit_strobe     = strobe;

`ifdef PSK_SEQ_SCRAMBLE_EN
    logic [6:0] lfsr;
    logic       scr_seed;
    logic       scr_adv;

    assign scr_fb   = lfsr[6] ^ lfsr[5];
    assign scr_seed = (state == IDLE) && handshake;
    assign scr_adv  = strobe_n && ((state_n == DATA) || (state_n == DRAIN));

    // PN7 state: reseeded at each burst start, stepped once per emitted data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 7'h7F;
        end else if (scr_seed) begin
            lfsr <= 7'h7F;
        end else if (scr_adv) begin
            lfsr <= {lfsr[5:0], scr_fb};
        end
    end
`else
    assign scr_fb = 1'b0;
`endif

    // State, timing and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_l     <= '0;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            idx       <= '0;
            ser       <= 1'b0;
            strobe    <= 1'b0;
        end else begin
            state     <= state_n;
            div_l     <= div_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            idx       <= idx_n;
            ser       <= ser_n;
            strobe    <= strobe_n;
        end
    end

    // Next-state and next-bit selection; each bit is registered onto the output
    always_comb begin
        state_n     = state;
        div_n       = div_l;
        cnt_n       = bit_end ? '0 : cnt + 1'b1;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        idx_n       = idx;
        ser_n       = ser;
        strobe_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                ser_n = 1'b0;
                if (handshake) begin
                    div_n       = bit_div;
                    shreg_n     = tx_data;
                    hold_full_n = 1'b0;
                    idx_n       = '0;
                    ser_n       = 1'b1;
                    strobe_n    = 1'b1;
                    state_n     = PRE;
                end
            end
            PRE: begin
                if (handshake) begin
                    hold_n      = tx_data;
                    hold_full_n = 1'b1;
                end
                if (bit_end) begin
                    strobe_n = 1'b1;
                    if (idx == PRE_LAST) begin
                        ser_n   = shreg[WORD_W-1] ^ scr_fb;
                        idx_n   = '0;
                        state_n = enable ? DATA : DRAIN;
                    end else begin
                        ser_n = ~ser;
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                if (!enable) begin
                    state_n = DRAIN;
                end
                if (bit_end && (idx == WORD_LAST)) begin
                    strobe_n = 1'b1;
                    idx_n    = '0;
                    if (hold_full) begin
                        shreg_n     = hold;
                        hold_full_n = 1'b0;
                        ser_n       = hold[WORD_W-1] ^ scr_fb;
                    end else if (handshake) begin
                        shreg_n = tx_data;
                        ser_n   = tx_data[WORD_W-1] ^ scr_fb;
                    end else begin
                        state_n  = IDLE;
                        ser_n    = 1'b0;
                        strobe_n = 1'b0;
                    end
                end else begin
                    if (handshake) begin
                        hold_n      = tx_data;
                        hold_full_n = 1'b1;
                    end
                    if (bit_end) begin
                        strobe_n = 1'b1;
                        shreg_n  = {shreg[WORD_W-2:0], 1'b0};
                        ser_n    = shreg[WORD_W-2] ^ scr_fb;
                        idx_n    = idx + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_psk_burst_sequencer.sv
// tb_psk_burst_sequencer: directed self-checking bench for psk_burst_sequencer.
// Expected serial streams come from a bit queue built from preamble and words.
module tb_psk_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] bit_div;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        m_ser_code_out;
    logic        bit_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
`ifdef PSK_SEQ_SCRAMBLE_EN
    logic [6:0] m_lfsr;
`endif

    psk_burst_sequencer #(.DIV_W(16), .WORD_W(8), .PRE_LEN(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .bit_div        (bit_div),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .m_ser_code_out (m_ser_code_out),
        .bit_strobe     (bit_strobe),
        .busy           (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic add_preamble();
        for (int i = 0; i < 8; i++) exp_q.push_back((i % 2) == 0);
`ifdef PSK_SEQ_SCRAMBLE_EN
        m_lfsr = 7'h7F;
`endif
    endtask

    task automatic add_word(input logic [7:0] w);
        bit b;
`ifdef PSK_SEQ_SCRAMBLE_EN
        bit fb;
`endif
        for (int i = 7; i >= 0; i--) begin
            b = w[i];
`ifdef PSK_SEQ_SCRAMBLE_EN
            fb     = m_lfsr[6] ^ m_lfsr[5];
            b      = b ^ fb;
            m_lfsr = {m_lfsr[5:0], fb};
`endif
            exp_q.push_back(b);
        end
    endtask

    // Presents a word at a negedge and returns just after the accepting posedge
    task automatic send_word(input logic [15:0] div, input logic [7:0] w, input logic keep_valid);
        @(negedge clk);
        bit_div  = div;
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_ser_code_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_out got %b expected 0", m_ser_code_out); end
        checks++; if (bit_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got %b expected 0", bit_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", tx_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready got %b expected 1", tx_ready); end
    endtask

    task automatic test_single();
        int  strobes = 0;
        logic e;
        exp_q.delete(); add_preamble(); add_word(8'hA5);
        send_word(16'd3, 8'hA5, 1'b0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            e = exp_q[k / 4];
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL single_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
            checks++; if (bit_strobe !== ((k % 4) == 0)) begin errors++; $display("[TB] FAIL single_strobe cycle %0d got %b", k, bit_strobe); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy cycle %0d got %b expected 1", k, busy); end
            if (bit_strobe === 1'b1) strobes++;
        end
        checks++; if (strobes != 16) begin errors++; $display("[TB] FAIL single_strobe_count got %0d expected 16", strobes); end
        @(negedge clk);
        checks++; if (m_ser_code_out !== 1'b0) begin errors++; $display("[TB] FAIL single_end_out got %b expected 0", m_ser_code_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_end_busy got %b expected 0", busy); end
        checks++; if (bit_strobe !== 1'b0) begin errors++; $display("[TB] FAIL single_end_strobe got %b expected 0", bit_strobe); end
    endtask

    task automatic test_back_to_back();
        logic e;
        logic r;
        exp_q.delete(); add_preamble(); add_word(8'hFF); add_word(8'h00);
        send_word(16'd0, 8'hFF, 1'b1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            e = exp_q[k];
            r = (k == 0) || (k >= 16);
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL b2b_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
            checks++; if (bit_strobe !== 1'b1) begin errors++; $display("[TB] FAIL b2b_strobe cycle %0d got %b expected 1", k, bit_strobe); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy cycle %0d got %b expected 1", k, busy); end
            checks++; if (tx_ready !== r) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d got %b expected %b", k, tx_ready, r); end
            if (k == 0) tx_data = 8'h00;
            if (k == 1) tx_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_busy got %b expected 0", busy); end
        checks++; if (m_ser_code_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_out got %b expected 0", m_ser_code_out); end
    endtask

    task automatic test_enable_drop();
        logic e;
        exp_q.delete(); add_preamble(); add_word(8'hC3); add_word(8'h5A);
        send_word(16'd1, 8'hC3, 1'b1);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k == 0) tx_data = 8'h5A;
            if (k == 1) tx_data = 8'hFF;
            if (k == 20) enable = 1'b0;
            e = exp_q[k / 2];
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL drop_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy cycle %0d got %b expected 1", k, busy); end
            checks++; if (tx_ready !== (k == 0)) begin errors++; $display("[TB] FAIL drop_ready cycle %0d got %b", k, tx_ready); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle_busy cycle %0d got %b expected 0", k, busy); end
            checks++; if (m_ser_code_out !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle_out cycle %0d got %b expected 0", k, m_ser_code_out); end
        end
        tx_valid = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic e;
        send_word(16'd3, 8'h3C, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (m_ser_code_out !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out got %b expected 0", m_ser_code_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b expected 0", busy); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready got %b expected 0", tx_ready); end
        checks++; if (bit_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_strobe got %b expected 0", bit_strobe); end
        rst = 1'b0;
        exp_q.delete(); add_preamble(); add_word(8'h81);
        send_word(16'd0, 8'h81, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = exp_q[k];
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL rstmid_new_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
            checks++; if (bit_strobe !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_new_strobe cycle %0d got %b expected 1", k, bit_strobe); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_end_busy got %b expected 0", busy); end
    endtask

    task automatic test_div_change();
        logic e;
        exp_q.delete(); add_preamble(); add_word(8'hF0);
        send_word(16'd3, 8'hF0, 1'b0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 2) bit_div = 16'd7;
            e = exp_q[k / 4];
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL div1_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
            checks++; if (bit_strobe !== ((k % 4) == 0)) begin errors++; $display("[TB] FAIL div1_strobe cycle %0d got %b", k, bit_strobe); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL div1_end_busy got %b expected 0", busy); end
        exp_q.delete(); add_preamble(); add_word(8'h0F);
        send_word(16'd7, 8'h0F, 1'b0);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            e = exp_q[k / 8];
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL div2_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
            checks++; if (bit_strobe !== ((k % 8) == 0)) begin errors++; $display("[TB] FAIL div2_strobe cycle %0d got %b", k, bit_strobe); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL div2_end_busy got %b expected 0", busy); end
    endtask

`ifdef PSK_SEQ_SCRAMBLE_EN
    task automatic test_scramble();
        logic [15:0] pat;
        logic        e;
        pat = 16'hAA02;
        send_word(16'd0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e = pat[15-k];
            checks++; if (m_ser_code_out !== e) begin errors++; $display("[TB] FAIL scramble_out cycle %0d got %b expected %b", k, m_ser_code_out, e); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL scramble_end_busy got %b expected 0", busy); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        bit_div  = 16'd0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_div_change();
`ifdef PSK_SEQ_SCRAMBLE_EN
        test_scramble();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk_burst_sequencer.md
Name: psk_burst_sequencer

Overview:
- Drives the serial code input of the 2PSK modulator mux, which selects carrier phase per bit.
- Accepts parallel data words over a valid/ready handshake and serializes them MSB-first at a programmable bit rate.
- Prefixes each burst with an alternating-bit preamble for receiver carrier and bit sync.
- Holds one word in a buffer so consecutive words stream with no gap.

Parameters:
- DIV_W, 16, width of the bit-period divider.
- WORD_W, 8, data word width.
- PRE_LEN, 8, preamble length in bits (must be ≥1).

Ports:
- clk  in  1  system clock, same clock as the DDS carriers.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits new bursts; deassertion stops gracefully.
- bit_div  in  DIV_W  bit period minus one, in clk cycles.
- tx_data  in  WORD_W  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  word accepted on a cycle with tx_valid && tx_ready.
- m_ser_code_out  out  1  serial code to the modulator select: 1 selects phase 0, 0 selects phase 180.
- bit_strobe  out  1  one-cycle pulse on the first cycle of each new bit.
- busy  out  1  high while the block is outside IDLE.

Behaviour:
- Reset values: m_ser_code_out=0, bit_strobe=0, busy=0, tx_ready=0. Reset also clears state, buffer and counters.
- Reset mid-burst aborts immediately; the shift word and buffered word are discarded.
- States are IDLE, PRE, DATA, DRAIN.
- IDLE:
  - tx_ready = enable.
  - On handshake, latch div_l <= bit_div, latch the word into shreg, clear cnt, go to PRE.
  - On the next edge, m_ser_code_out = 1 and bit_strobe = 1 (latency one cycle).
- Bit timing:
  - cnt counts 0..div_l; each bit lasts div_l+1 cycles. div_l=0 gives one bit per clk.
  - At cnt==div_l, cnt<=0 and the next bit is registered onto m_ser_code_out. bit_strobe is high in the cycle that bit first appears.
  - bit_div changes mid-burst are ignored; the new value is sampled only at the next burst start.
- PRE:
  - Outputs PRE_LEN bits alternating 1,0,1,… starting with 1.
  - After the last preamble bit period, shreg[MSB] becomes the output and the state goes to DATA.
- DATA:
  - Shifts shreg MSB-first, WORD_W bits per word.
  - Buffer: a one-word holding register plus a hold_full flag. tx_ready = enable && !hold_full.
  - A handshake during DATA fills the buffer.
  - At the end of the last bit of a word:
    - if hold_full: load shreg from the buffer, clear hold_full, continue in DATA with no preamble and no gap;
    - otherwise go to IDLE.
  - A handshake in the same cycle as the word-end load goes straight into shreg. This is legal only because hold_full is already clear.
- enable low during a burst:
  - tx_ready goes to 0 combinationally.
  - The current word and any buffered word complete (DRAIN behaves like DATA with tx_ready=0), then the block goes to IDLE.
- IDLE output:
  - m_ser_code_out returns to 0 on the edge that ends the final bit.
  - bit_strobe = 0 and busy = 0 from that same edge.
- Total burst length is PRE_LEN + N·WORD_W bits.

Optional Feature:
- Macro: PSK_SEQ_SCRAMBLE_EN.
- Defined: data bits (not preamble) are XORed with an additive PN7 scrambler.
  - LFSR s[6:0], seeded 7'h7F at each burst start (IDLE handshake).
  - Per data bit: fb = s[6]^s[5]; output = data_bit^fb; s <= {s[5:0],fb}.
  - The LFSR advances only on data bits and continues across chained words.
- Undefined: data is sent unscrambled; no LFSR logic is present.

Test Plan:
- bit_div=3, send 8'hA5 alone:
  - output is 1,0,1,0,1,0,1,0 then 1,0,1,0,0,1,0,1, each bit 4 cycles;
  - first bit appears 1 cycle after the handshake, with 16 bit_strobe pulses;
  - busy spans 64 cycles, then output=0 and busy=0.
- bit_div=0, tx_valid held with 8'hFF then 8'h00:
  - one preamble, then 8 ones immediately followed by 8 zeros, no gap;
  - tx_ready drops while the buffer is full; total 24 cycles busy.
- bit_div=1, drop enable during the 3rd data bit with one word buffered:
  - current word and buffered word both complete, no new handshake accepted, then IDLE.
- Assert rst during the preamble:
  - the next cycle shows m_ser_code_out=0, busy=0, tx_ready=0;
  - a new burst after reset starts again with the full preamble.
- Change bit_div from 3 to 7 mid-burst: the bit period stays 4 cycles until the next burst, which uses 8.
- With PSK_SEQ_SCRAMBLE_EN, send 8'h00: the data bits are 0,0,0,0,0,0,1,0 (8'h02) and the preamble is unchanged.
